// File: rtl/fastclkdiv_seq.sv
// Sequencer for a single fastclkdiv down-counter. It runs the divider for a
// burst of N periods, or free-running when N is 0. A shadowed period register
// takes effect only at a reload, so the running period is never cut short.
module fastclkdiv_seq #(
    parameter int unsigned NBITS        = 9,
    parameter int unsigned NCNT_BITS    = 16,
    parameter int unsigned ZERO_HOLDOFF = 0
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic                 i_stop,
    input  logic [NCNT_BITS-1:0] i_nperiods,
    input  logic [NBITS-1:0]     i_period,
    input  logic                 i_period_wr,
    output logic                 o_div_en,
    output logic                 o_div_load,
    output logic [NBITS-1:0]     o_div_load_q,
    input  logic                 i_div_zero,
    output logic                 o_busy,
    output logic                 o_tick,
    output logic                 o_done,
    output logic [NCNT_BITS-1:0] o_periods_left
);

    typedef enum logic [1:0] {
        StIdle,
        StArm,
        StRun
    } state_e;

    localparam logic [2:0]           HoldoffInit = 3'(ZERO_HOLDOFF);
    localparam logic [NCNT_BITS-1:0] CntOne      = NCNT_BITS'(1);

    state_e                 state_q;
    logic [NBITS-1:0]       active_q;
    logic [NBITS-1:0]       shadow_q;
    logic                   pending_q;
    logic [NCNT_BITS-1:0]   left_q;
    logic                   finite_q;
    logic [2:0]             holdoff_q;
    logic                   tick_q;
    logic                   done_q;

    logic                   zero_ev;
    logic                   last_zero;
    logic                   load;

    // Zero events are masked while the divider may still show a stale zero after a load.
    always_comb begin
        zero_ev   = (state_q == StRun) && i_div_zero && (holdoff_q == 3'd0);
        last_zero = zero_ev && finite_q && (left_q == CntOne);
        // Reload on every non-final zero; stop (and reset) suppress any load.
        load      = !i_rst && !i_stop &&
                    ((state_q == StArm) || (zero_ev && !last_zero));
    end

    // Main FSM with its registered tick/done pulses and burst bookkeeping.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= StIdle;
            left_q    <= '0;
            finite_q  <= 1'b0;
            holdoff_q <= 3'd0;
            tick_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            tick_q <= 1'b0;
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (i_start && !i_stop) begin
                        left_q   <= i_nperiods;
                        finite_q <= (i_nperiods != '0);
                        state_q  <= StArm;
                    end
                end
                StArm: begin
                    if (i_stop) begin
                        left_q  <= '0;
                        state_q <= StIdle;
                    end else begin
                        holdoff_q <= HoldoffInit;
                        state_q   <= StRun;
                    end
                end
                StRun: begin
                    if (i_stop) begin
                        left_q  <= '0;
                        state_q <= StIdle;
                    end else if (zero_ev) begin
                        tick_q <= 1'b1;
                        if (finite_q) begin
                            left_q <= left_q - CntOne;
                        end
                        if (last_zero) begin
                            done_q  <= 1'b1;
                            state_q <= StIdle;
                        end else begin
                            holdoff_q <= HoldoffInit;
                        end
                    end else if (holdoff_q != 3'd0) begin
                        holdoff_q <= holdoff_q - 3'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Period registers: a write while busy is shadowed until the next reload.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            active_q  <= '0;
            shadow_q  <= '0;
            pending_q <= 1'b0;
        end else begin
            // Reload consumes the old shadow first; a same-cycle write re-arms pending.
            if (load && pending_q) begin
                active_q  <= shadow_q;
                pending_q <= 1'b0;
            end
            if (i_period_wr) begin
                if (state_q == StIdle) begin
                    active_q  <= i_period;
                    pending_q <= 1'b0;
                end else begin
                    shadow_q  <= i_period;
                    pending_q <= 1'b1;
                end
            end
        end
    end

    // Output decode.
    always_comb begin
        o_div_en       = (state_q == StRun);
        o_div_load     = load;
        o_div_load_q   = pending_q ? shadow_q : active_q;
        o_busy         = (state_q != StIdle);
        o_tick         = tick_q;
        o_done         = done_q;
        o_periods_left = left_q;
    end

endmodule

// File: tb/tb_fastclkdiv_seq.sv
// Bench for fastclkdiv_seq: two instances, one with a plain divider model and
// one (ZERO_HOLDOFF=2) with a divider whose reload lands two cycles late.
// Expected ticks are queued when a burst starts and matched as they appear.
module tb_fastclkdiv_seq;

    typedef struct {
        int cyc;
        bit done;
    } exp_t;

    logic clk = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    exp_t sb0[$];
    exp_t sb1[$];

    // DUT 0 (no holdoff)
    logic        rst0, st0, sp0, pw0, z0;
    logic [15:0] np0;
    logic [8:0]  per0;
    logic        en0, ld0, busy0, tick0, done0;
    logic [8:0]  lq0;
    logic [15:0] left0;
    logic [8:0]  q0;

    // DUT 1 (holdoff 2)
    logic        rst1, st1, sp1, pw1, z1;
    logic [15:0] np1;
    logic [8:0]  per1;
    logic        en1, ld1, busy1, tick1, done1;
    logic [8:0]  lq1;
    logic [15:0] left1;
    logic [8:0]  q1, v1a, v1b;
    logic        l1a, l1b;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fastclkdiv_seq u_dut0 (
        .i_clk(clk), .i_rst(rst0), .i_start(st0), .i_stop(sp0), .i_nperiods(np0),
        .i_period(per0), .i_period_wr(pw0), .o_div_en(en0), .o_div_load(ld0),
        .o_div_load_q(lq0), .i_div_zero(z0), .o_busy(busy0), .o_tick(tick0),
        .o_done(done0), .o_periods_left(left0)
    );

    fastclkdiv_seq #(.ZERO_HOLDOFF(2)) u_dut1 (
        .i_clk(clk), .i_rst(rst1), .i_start(st1), .i_stop(sp1), .i_nperiods(np1),
        .i_period(per1), .i_period_wr(pw1), .o_div_en(en1), .o_div_load(ld1),
        .o_div_load_q(lq1), .i_div_zero(z1), .o_busy(busy1), .o_tick(tick1),
        .o_done(done1), .o_periods_left(left1)
    );

    // Plain divider model.
    always @(posedge clk) begin
        if (rst0) q0 <= '0;
        else if (ld0) q0 <= lq0;
        else if (en0 && q0 != 9'd0) q0 <= q0 - 9'd1;
    end
    assign z0 = (q0 == 9'd0);

    // Divider model whose load reaches the counter two cycles late.
    always @(posedge clk) begin
        if (rst1) begin
            q1 <= '0; l1a <= 1'b0; l1b <= 1'b0; v1a <= '0; v1b <= '0;
        end else begin
            l1a <= ld1; v1a <= lq1; l1b <= l1a; v1b <= v1a;
            if (l1b) q1 <= v1b;
            else if (en1 && q1 != 9'd0) q1 <= q1 - 9'd1;
        end
    end
    assign z1 = (q1 == 9'd0);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    // Tick scoreboards, sampled on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (tick0) begin
            if (sb0.size() == 0) chk("tick0_unexpected", 32'(tick0), 0);
            else begin
                e = sb0.pop_front();
                chk("tick0_cycle", cyc, e.cyc);
                chk("tick0_done", 32'(done0), 32'(e.done));
            end
        end else if (done0) chk("done0_without_tick", 32'(done0), 0);
    end

    always @(negedge clk) begin
        exp_t e;
        if (tick1) begin
            if (sb1.size() == 0) chk("tick1_unexpected", 32'(tick1), 0);
            else begin
                e = sb1.pop_front();
                chk("tick1_cycle", cyc, e.cyc);
                chk("tick1_done", 32'(done1), 32'(e.done));
            end
        end else if (done1) chk("done1_without_tick", 32'(done1), 0);
    end

    // All tasks below are entered and left on a falling edge.
    task automatic go_to(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic push0(input int c, input bit d);
        exp_t e;
        e.cyc = c; e.done = d;
        sb0.push_back(e);
    endtask

    task automatic push1(input int c, input bit d);
        exp_t e;
        e.cyc = c; e.done = d;
        sb1.push_back(e);
    endtask

    task automatic wr0(input logic [8:0] p);
        per0 = p; pw0 = 1'b1;
        @(negedge clk);
        pw0 = 1'b0;
    endtask

    task automatic wr1(input logic [8:0] p);
        per1 = p; pw1 = 1'b1;
        @(negedge clk);
        pw1 = 1'b0;
    endtask

    // Returns c0 = cycle count just after the edge that samples i_start (E0).
    task automatic start0(input logic [15:0] n, output int c0);
        np0 = n; st0 = 1'b1; c0 = cyc + 1;
        @(negedge clk);
        st0 = 1'b0;
    endtask

    task automatic start1(input logic [15:0] n, output int c0);
        np1 = n; st1 = 1'b1; c0 = cyc + 1;
        @(negedge clk);
        st1 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        int c0;
        int c;
        rst0 = 1'b1; st0 = 1'b0; sp0 = 1'b0; pw0 = 1'b0; np0 = '0; per0 = '0;
        rst1 = 1'b1; st1 = 1'b0; sp1 = 1'b0; pw1 = 1'b0; np1 = '0; per1 = '0;
        repeat (3) @(negedge clk);
        chk("rst0_busy", 32'(busy0), 0);
        chk("rst0_en", 32'(en0), 0);
        chk("rst0_load", 32'(ld0), 0);
        chk("rst0_load_q", 32'(lq0), 0);
        chk("rst0_left", 32'(left0), 0);
        chk("rst1_busy", 32'(busy1), 0);
        rst0 = 1'b0; rst1 = 1'b0;
        @(negedge clk);

        // 1: P=4, N=3 burst.
        wr0(9'd4);
        start0(16'd3, c0);
        push0(c0 + 6, 1'b0); push0(c0 + 11, 1'b0); push0(c0 + 16, 1'b1);
        chk("t1_arm_left", 32'(left0), 3);
        chk("t1_arm_load", 32'(ld0), 1);
        chk("t1_arm_en", 32'(en0), 0);
        chk("t1_arm_load_q", 32'(lq0), 4);
        go_to(c0 + 1);
        chk("t1_run_en", 32'(en0), 1);
        go_to(c0 + 6);
        chk("t1_left_a", 32'(left0), 2);
        go_to(c0 + 11);
        chk("t1_left_b", 32'(left0), 1);
        go_to(c0 + 15);
        chk("t1_busy_before_end", 32'(busy0), 1);
        go_to(c0 + 16);
        chk("t1_left_end", 32'(left0), 0);
        chk("t1_busy_end", 32'(busy0), 0);
        chk("t1_en_end", 32'(en0), 0);
        go_to(c0 + 20);

        // 2: free-running P=2, then stop.
        wr0(9'd2);
        start0(16'd0, c0);
        push0(c0 + 4, 1'b0); push0(c0 + 7, 1'b0); push0(c0 + 10, 1'b0);
        go_to(c0 + 5);
        chk("t2_left_free", 32'(left0), 0);
        go_to(c0 + 11);
        sp0 = 1'b1;
        go_to(c0 + 12);
        sp0 = 1'b0;
        chk("t2_stop_en", 32'(en0), 0);
        chk("t2_stop_busy", 32'(busy0), 0);
        go_to(c0 + 20);

        // 3: shadow write mid-period, P=4 -> P=1.
        wr0(9'd4);
        start0(16'd0, c0);
        push0(c0 + 6, 1'b0); push0(c0 + 11, 1'b0); push0(c0 + 13, 1'b0); push0(c0 + 15, 1'b0);
        go_to(c0 + 5);
        chk("t3_reload_a_q", 32'(lq0), 4);
        go_to(c0 + 6);
        per0 = 9'd1; pw0 = 1'b1;
        go_to(c0 + 7);
        pw0 = 1'b0;
        go_to(c0 + 10);
        chk("t3_reload_b", 32'(ld0), 1);
        chk("t3_reload_b_q", 32'(lq0), 1);
        go_to(c0 + 15);
        sp0 = 1'b1;
        go_to(c0 + 16);
        sp0 = 1'b0;
        chk("t3_stop_busy", 32'(busy0), 0);
        go_to(c0 + 22);

        // 4: P=0, N=5 -> tick every cycle.
        wr0(9'd0);
        start0(16'd5, c0);
        for (int i = 2; i <= 6; i++) push0(c0 + i, (i == 6));
        go_to(c0 + 4);
        chk("t4_left_mid", 32'(left0), 2);
        go_to(c0 + 7);
        chk("t4_busy_end", 32'(busy0), 0);
        go_to(c0 + 10);

        // 5: stop coincident with final zero; start+stop while idle.
        wr0(9'd2);
        start0(16'd2, c0);
        push0(c0 + 4, 1'b0);
        go_to(c0 + 6);
        sp0 = 1'b1;
        go_to(c0 + 7);
        sp0 = 1'b0;
        chk("t5_stop_busy", 32'(busy0), 0);
        chk("t5_stop_left", 32'(left0), 0);
        chk("t5_stop_done", 32'(done0), 0);
        c = cyc + 1;
        st0 = 1'b1; sp0 = 1'b1;
        go_to(c);
        st0 = 1'b0; sp0 = 1'b0;
        chk("t5_startstop_busy", 32'(busy0), 0);
        chk("t5_startstop_load", 32'(ld0), 0);
        go_to(c + 5);

        // 6: holdoff with a lagging divider, then reset mid-burst.
        wr1(9'd3);
        start1(16'd2, c0);
        push1(c0 + 7, 1'b0); push1(c0 + 13, 1'b1);
        go_to(c0 + 14);
        chk("t6_busy_end", 32'(busy1), 0);
        start1(16'd5, c0);
        go_to(c0 + 4);
        chk("t6_busy_mid", 32'(busy1), 1);
        rst1 = 1'b1;
        go_to(c0 + 5);
        rst1 = 1'b0;
        chk("t6_rst_en", 32'(en1), 0);
        chk("t6_rst_load", 32'(ld1), 0);
        chk("t6_rst_load_q", 32'(lq1), 0);
        chk("t6_rst_busy", 32'(busy1), 0);
        chk("t6_rst_tick", 32'(tick1), 0);
        chk("t6_rst_done", 32'(done1), 0);
        chk("t6_rst_left", 32'(left1), 0);
        go_to(c0 + 15);

        chk("sb0_drained", sb0.size(), 0);
        chk("sb1_drained", sb1.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
